uart_rx_fifo: RTL and testbench

//  Receive side of the SoC UART links (ISP and user UART): deserialises 8N1 frames

---
 rtl/uart_rx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with mid-bit sampling feeding a show-ahead byte FIFO
// with a valid/ready read port, framing-error and overflow pulses.
module uart_rx_fifo #(
  parameter int CLK_DIV = 434,
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               frame_err,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_count
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0] HALF = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t             state_q, state_d;
  logic               s1_q, s2_q, s3_q;
  logic [1:0]         vld_q, vld_d;
  logic               armed_q, armed_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               push_q, push_d;
  logic               ferr_q, ferr_d;
  logic               ovf_q, ovf_d;
  logic [FIFO_AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]         mem_q [DEPTH];
  logic               fall, cnt_z, full, pop, wr;
  logic [FIFO_AW:0]   count;
  // The synchroniser presets high, so a line already low at reset release would
  // look like an edge; armed_q waits until a genuinely sampled high has been seen.
  always_comb begin
    vld_d   = {vld_q[0], 1'b1};
    armed_d = armed_q | (vld_q[1] & s2_q);
    fall    = armed_q & s3_q & ~s2_q;
    cnt_z   = cnt_q == 16'd0;
    state_d = state_q;
    cnt_d   = cnt_z ? cnt_q : cnt_q - 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: if (fall) begin
        cnt_d   = HALF;
        state_d = START;
      end
      START: if (cnt_z) begin
        cnt_d   = FULL;
        bit_d   = 3'd0;
        state_d = s2_q ? IDLE : DATA;
      end
      DATA: if (cnt_z) begin
        shift_d = {s2_q, shift_q[7:1]};
        cnt_d   = FULL;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (cnt_z) begin
        push_d  = s2_q;
        ferr_d  = ~s2_q;
        state_d = IDLE;
      end
    endcase
  end
  always_comb begin
    count  = wptr_q - rptr_q;
    full   = count == (FIFO_AW + 1)'(DEPTH);
    pop    = (count != '0) & rx_ready;
    wr     = push_q & (~full | pop);
    wptr_d = wptr_q + (FIFO_AW + 1)'(wr);
    rptr_d = rptr_q + (FIFO_AW + 1)'(pop);
    ovf_d  = push_q & full & ~pop;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
      vld_q   <= '0;
      armed_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      s1_q    <= rx;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      vld_q   <= vld_d;
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[FIFO_AW-1:0]] <= shift_q;
  end
  assign rx_valid   = count != '0;
  assign rx_data    = rx_valid ? mem_q[rptr_q[FIFO_AW-1:0]] : 8'h00;
  assign fifo_count = count;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scenario tasks drive 8N1 frames; expected bytes queue in a
// scoreboard and are compared as they are popped from the FIFO.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overflow;
  logic [3:0] fifo_count;
  logic [7:0] exp_q[$];
  int         tests = 0, fails = 0, fe_cnt = 0, ov_cnt = 0;

  uart_rx_fifo #(.CLK_DIV(8), .FIFO_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (frame_err) fe_cnt++;
    if (overflow) ov_cnt++;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic pop_expect(input string name);
    logic [7:0] e;
    int n = 0;
    while (!rx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!rx_valid) begin
      fails++;
      $display("FAIL %s: rx_valid=0 after %0d cycles, required 1", name, n);
    end else if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: unexpected byte %02h, required no data", name, rx_data);
    end else begin
      e = exp_q.pop_front();
      if (rx_data !== e) begin
        fails++;
        $display("FAIL %s: rx_data=%02h required %02h", name, rx_data, e);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({rx_valid, rx_data, frame_err, overflow, fifo_count} !== 15'd0) begin
      fails++;
      $display("FAIL reset_hold: outputs=%h required 0", {rx_valid, rx_data, frame_err, overflow, fifo_count});
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tests++;
    if ({rx_valid, rx_data, frame_err, overflow, fifo_count} !== 15'd0) begin
      fails++;
      $display("FAIL reset_idle: outputs=%h required 0", {rx_valid, rx_data, frame_err, overflow, fifo_count});
    end
  endtask

  task automatic test_single();
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    repeat (2) @(negedge clk);
    tests++;
    if (rx_valid !== 1'b1 || fifo_count !== 4'd1) begin
      fails++;
      $display("FAIL single_status: valid=%b count=%0d required 1/1", rx_valid, fifo_count);
    end
    pop_expect("single_data");
    tests++;
    if (rx_valid !== 1'b0 || fifo_count !== 4'd0) begin
      fails++;
      $display("FAIL single_pop: valid=%b count=%0d required 0/0", rx_valid, fifo_count);
    end
  endtask

  task automatic test_glitch();
    int fe0 = fe_cnt;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    tests++;
    if (rx_valid !== 1'b0 || fe_cnt != fe0) begin
      fails++;
      $display("FAIL glitch: valid=%b frame_errs=%0d required 0/0", rx_valid, fe_cnt - fe0);
    end
  endtask

  task automatic test_frame_err();
    int fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0);
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    tests++;
    if (fe_cnt - fe0 != 1 || rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL frame_err: pulses=%0d valid=%b required 1/0", fe_cnt - fe0, rx_valid);
    end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    pop_expect("after_ferr_data");
  endtask

  task automatic test_back_to_back();
    int ov0 = ov_cnt;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (fifo_count !== 4'd8 || ov_cnt - ov0 != 1) begin
      fails++;
      $display("FAIL b2b_full: count=%0d overflows=%0d required 8/1", fifo_count, ov_cnt - ov0);
    end
    for (int i = 0; i < 8; i++) pop_expect("b2b_data");
  endtask

  task automatic test_full_push_pop();
    int ov0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      send_frame(8'h10 + 8'(i), 1'b1);
    end
    repeat (3) @(negedge clk);
    ov0 = ov_cnt;
    tests++;
    if (fifo_count !== 4'd8) begin
      fails++;
      $display("FAIL pp_prefill: count=%0d required 8", fifo_count);
    end
    exp_q.push_back(8'h7E);
    fork
      send_frame(8'h7E, 1'b1);
      begin
        repeat (79) @(negedge clk);
        tests++;
        if (rx_data !== exp_q[0]) begin
          fails++;
          $display("FAIL pp_head: rx_data=%02h required %02h", rx_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    tests++;
    if (fifo_count !== 4'd8 || ov_cnt != ov0) begin
      fails++;
      $display("FAIL pp_status: count=%0d overflows=%0d required 8/0", fifo_count, ov_cnt - ov0);
    end
    for (int i = 0; i < 8; i++) pop_expect("pp_data");
  endtask

  task automatic test_reset_mid_frame();
    int fe0;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (3) @(negedge clk);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({rx_valid, rx_data, frame_err, overflow, fifo_count} !== 15'd0) begin
      fails++;
      $display("FAIL midreset_out: outputs=%h required 0", {rx_valid, rx_data, frame_err, overflow, fifo_count});
    end
    exp_q.delete();
    fe0 = fe_cnt;
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    tests++;
    if (rx_valid !== 1'b0 || fe_cnt != fe0) begin
      fails++;
      $display("FAIL midreset_ignore: valid=%b frame_errs=%0d required 0/0", rx_valid, fe_cnt - fe0);
    end
    exp_q.push_back(8'hC9);
    send_frame(8'hC9, 1'b1);
    repeat (2) @(negedge clk);
    tests++;
    if (fifo_count !== 4'd1) begin
      fails++;
      $display("FAIL midreset_count: count=%0d required 1", fifo_count);
    end
    pop_expect("midreset_data");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_full_push_pop();
    test_reset_mid_frame();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d bytes left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
